// File: rtl/dcache_mem_responder_pkg.sv
// Shared constants for the dcache memory-side responder.
package dcache_mem_responder_pkg;

  // FSM state encodings
  localparam int unsigned STATE_W = 3;
  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_RD_LAT_WAIT = 3'd1;
  localparam logic [2:0] S_RD_BURST    = 3'd2;
  localparam logic [2:0] S_WR_LAT_WAIT = 3'd3;
  localparam logic [2:0] S_TURN        = 3'd4;

  // Address map and word geometry
  localparam logic [31:0] MEM_BASE_DEFAULT = 32'h8000_0000;
  localparam int unsigned WORD_BYTES       = 8;

  // One-hot access sizes
  localparam logic [3:0] SIZE_1 = 4'b0001;
  localparam logic [3:0] SIZE_2 = 4'b0010;
  localparam logic [3:0] SIZE_4 = 4'b0100;
  localparam logic [3:0] SIZE_8 = 4'b1000;

  // Latency counter width
  localparam int unsigned LAT_W = 8;

endpackage

// File: rtl/dcache_mem_array.sv
// Single-port 64-bit word array with byte write enables and a registered read port.
module dcache_mem_array
  import dcache_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic                  i_re,
  input  logic [7:0]            i_be,
  input  logic [63:0]           i_wdata,
  output logic [63:0]           o_rdata
);

  logic [63:0] r_mem [0:(1 << DEPTH_LOG2)-1];
  logic [63:0] r_rdata;

  // Byte-lane writes; contents are never reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(WORD_BYTES); i++) begin
      if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
    end
  end

  // Registered read; holds its value between reads
  always_ff @(posedge clk) begin
    if (i_rst)     r_rdata <= 64'd0;
    else if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dcache_mem_responder.sv
// Memory-side responder: burst reads, masked single-beat writes, fixed latencies.
module dcache_mem_responder
  import dcache_mem_responder_pkg::*;
#(
  parameter logic [31:0] MEM_BASE   = MEM_BASE_DEFAULT,
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned WR_LAT     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] raddr_i,
  input  logic        raddr_valid_i,
  input  logic [7:0]  rmask_i,
  input  logic [3:0]  rsize_i,
  input  logic [7:0]  rlen_i,
  output logic        rdata_ready_o,
  output logic [63:0] rdata_o,
  input  logic [31:0] waddr_i,
  input  logic        waddr_valid_i,
  input  logic [7:0]  wmask_i,
  input  logic [3:0]  wsize_i,
  input  logic [7:0]  wlen_i,
  input  logic [63:0] wdata_i,
  output logic        wdata_ready_o
);

  logic [STATE_W-1:0]    r_state, w_next_state;
  logic [LAT_W-1:0]      r_lat_cnt, w_next_lat;
  logic [7:0]            r_beat_cnt, w_next_beat;
  logic [7:0]            r_rlen;
  logic [DEPTH_LOG2-1:0] r_rd_idx, w_next_rd_idx;
  logic [DEPTH_LOG2-1:0] r_wr_idx;
  logic [7:0]            r_wmask;
  logic [63:0]           r_wdata;
  logic                  r_rdata_ready, r_wdata_ready;

  logic [DEPTH_LOG2-1:0] w_req_rd_idx, w_req_wr_idx, w_mem_addr;
  logic                  w_mem_re, w_acc_rd, w_acc_wr, w_rd_violation;
  logic [7:0]            w_mem_be;
  logic [63:0]           w_mem_rdata;
  logic                  w_unused;

  // Word index of the incoming request; wraps modulo the array depth
  assign w_req_rd_idx = DEPTH_LOG2'((raddr_i - MEM_BASE) >> 3);
  assign w_req_wr_idx = DEPTH_LOG2'((waddr_i - MEM_BASE) >> 3);
  assign w_unused     = ^{rmask_i, wsize_i};

  // Next-state, counter and array-control logic
  always_comb begin
    w_next_state   = r_state;
    w_next_lat     = r_lat_cnt;
    w_next_beat    = r_beat_cnt;
    w_next_rd_idx  = r_rd_idx;
    w_mem_addr     = r_rd_idx;
    w_mem_re       = 1'b0;
    w_mem_be       = 8'd0;
    w_acc_rd       = 1'b0;
    w_acc_wr       = 1'b0;
    w_rd_violation = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (waddr_valid_i) begin
          w_acc_wr     = 1'b1;
          w_next_lat   = LAT_W'(WR_LAT - 1);
          w_next_state = S_WR_LAT_WAIT;
        end else if (raddr_valid_i) begin
          w_acc_rd    = 1'b1;
          w_next_beat = 8'd0;
          if (RD_LAT == 1) begin
            // First fetch issues now so the beat lands next cycle
            w_mem_addr    = w_req_rd_idx;
            w_mem_re      = 1'b1;
            w_next_rd_idx = w_req_rd_idx + DEPTH_LOG2'(1);
            w_next_state  = S_RD_BURST;
          end else begin
            w_next_rd_idx = w_req_rd_idx;
            w_next_lat    = LAT_W'(RD_LAT - 2);
            w_next_state  = S_RD_LAT_WAIT;
          end
        end
      end
      S_RD_LAT_WAIT: begin
        if (r_lat_cnt == '0) begin
          // Last wait cycle doubles as the array read cycle for beat 0
          w_mem_re      = 1'b1;
          w_next_rd_idx = r_rd_idx + DEPTH_LOG2'(1);
          w_next_state  = S_RD_BURST;
        end else begin
          w_next_lat = r_lat_cnt - LAT_W'(1);
        end
      end
      S_RD_BURST: begin
        if (!raddr_valid_i) begin
          w_rd_violation = 1'b1;
          w_next_state   = S_TURN;
        end else if (r_beat_cnt == r_rlen) begin
          w_next_state = S_TURN;
        end else begin
          w_next_beat   = r_beat_cnt + 8'd1;
          w_mem_re      = 1'b1;
          w_next_rd_idx = r_rd_idx + DEPTH_LOG2'(1);
        end
      end
      S_WR_LAT_WAIT: begin
        w_mem_addr = r_wr_idx;
        if (r_lat_cnt == '0) begin
          // Commit happens in the same cycle as the ready pulse
          w_mem_be     = r_wmask;
          w_next_state = S_TURN;
        end else begin
          w_next_lat = r_lat_cnt - LAT_W'(1);
        end
      end
      S_TURN:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State, counters, request latches and registered readies
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_lat_cnt     <= '0;
      r_beat_cnt    <= 8'd0;
      r_rlen        <= 8'd0;
      r_rd_idx      <= '0;
      r_wr_idx      <= '0;
      r_wmask       <= 8'd0;
      r_wdata       <= 64'd0;
      r_rdata_ready <= 1'b0;
      r_wdata_ready <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_lat_cnt     <= w_next_lat;
      r_beat_cnt    <= w_next_beat;
      r_rd_idx      <= w_next_rd_idx;
      r_rdata_ready <= (w_next_state == S_RD_BURST);
      r_wdata_ready <= (w_next_state == S_WR_LAT_WAIT) && (w_next_lat == '0);
      if (w_acc_rd) r_rlen <= rlen_i;
      if (w_acc_wr) begin
        r_wr_idx <= w_req_wr_idx;
        r_wmask  <= wmask_i;
        r_wdata  <= wdata_i;
      end
    end
  end

  // Protocol checks on the initiator side
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_acc_wr) assert (wlen_i == 8'd0);
      if (w_acc_rd) assert ($onehot(rsize_i));
      assert (!w_rd_violation);
      assert (!(r_rdata_ready && r_wdata_ready));
    end
  end

  dcache_mem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk    (clk),
    .i_rst  (rst),
    .i_addr (w_mem_addr),
    .i_re   (w_mem_re),
    .i_be   (w_mem_be),
    .i_wdata(r_wdata),
    .o_rdata(w_mem_rdata)
  );

  assign rdata_o       = w_mem_rdata;
  assign rdata_ready_o = r_rdata_ready;
  assign wdata_ready_o = r_wdata_ready;

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Directed bench for dcache_mem_responder (16-word array to exercise wrap/alias).
module tb_dcache_mem_responder;

  localparam int unsigned RD_LAT = 2;
  localparam int unsigned WR_LAT = 1;
  localparam logic [31:0] BASE   = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] raddr_i;
  logic        raddr_valid_i;
  logic [7:0]  rmask_i;
  logic [3:0]  rsize_i;
  logic [7:0]  rlen_i;
  logic        rdata_ready_o;
  logic [63:0] rdata_o;
  logic [31:0] waddr_i;
  logic        waddr_valid_i;
  logic [7:0]  wmask_i;
  logic [3:0]  wsize_i;
  logic [7:0]  wlen_i;
  logic [63:0] wdata_i;
  logic        wdata_ready_o;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q [8];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  mask;
    logic [63:0] data;
    logic [63:0] exp;
  } vec_t;

  dcache_mem_responder #(
    .MEM_BASE  (BASE),
    .DEPTH_LOG2(4),
    .RD_LAT    (RD_LAT),
    .WR_LAT    (WR_LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .raddr_i      (raddr_i),
    .raddr_valid_i(raddr_valid_i),
    .rmask_i      (rmask_i),
    .rsize_i      (rsize_i),
    .rlen_i       (rlen_i),
    .rdata_ready_o(rdata_ready_o),
    .rdata_o      (rdata_o),
    .waddr_i      (waddr_i),
    .waddr_valid_i(waddr_valid_i),
    .wmask_i      (wmask_i),
    .wsize_i      (wsize_i),
    .wlen_i       (wlen_i),
    .wdata_i      (wdata_i),
    .wdata_ready_o(wdata_ready_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Single-beat write starting in an IDLE cycle; ends in the TURN cycle
  task automatic do_write(input logic [31:0] a, input logic [7:0] m, input logic [63:0] d);
    int lat = 99;
    @(negedge clk);
    waddr_i = a; wmask_i = m; wdata_i = d; wlen_i = 8'd0; wsize_i = 4'b1000;
    waddr_valid_i = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      if (lat == 99) begin
        @(negedge clk);
        if (wdata_ready_o) lat = i;
      end
    end
    check("wr_lat", 64'(lat), 64'(WR_LAT));
    check("wr_no_rd_rdy", 64'(rdata_ready_o), 64'd0);
    waddr_valid_i = 1'b0;
    @(negedge clk);
    check("wr_turn", 64'(wdata_ready_o), 64'd0);
  endtask

  // Burst read expecting exp_q[k]; abort_k >= 0 applies reset after that beat
  task automatic do_read(input logic [31:0] a, input logic [7:0] len, input int abort_k);
    int lat = 99;
    @(negedge clk);
    raddr_i = a; rlen_i = len; rsize_i = 4'b1000; rmask_i = 8'hFF;
    raddr_valid_i = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      if (lat == 99) begin
        @(negedge clk);
        if (rdata_ready_o) lat = i;
      end
    end
    check("rd_lat", 64'(lat), 64'(RD_LAT));
    if (lat == 99) begin
      raddr_valid_i = 1'b0;
      return;
    end
    for (int k = 0; k <= int'(len); k++) begin
      if (k > 0) @(negedge clk);
      check("rd_beat_rdy", 64'(rdata_ready_o), 64'd1);
      check("rd_beat_data", rdata_o, exp_q[k]);
      check("rd_no_wr_rdy", 64'(wdata_ready_o), 64'd0);
      if (k == abort_k) begin
        rst = 1'b1;
        @(negedge clk);
        check("abort_rdy", 64'(rdata_ready_o), 64'd0);
        check("abort_data", rdata_o, 64'd0);
        rst = 1'b0;
        raddr_valid_i = 1'b0;
        return;
      end
    end
    @(negedge clk);
    check("rd_turn", 64'(rdata_ready_o), 64'd0);
    raddr_valid_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs [14];
    int   wr_at, rd_at, rbeats;
    bit   drop_r;

    vecs[0]  = '{1'b1, 32'h8000_0100, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
    vecs[1]  = '{1'b1, 32'h8000_0100, 8'h0C, 64'h0000_0000_AABB_0000, 64'd0};
    vecs[2]  = '{1'b0, 32'h8000_0100, 8'h00, 64'd0, 64'hFFFF_FFFF_AABB_FFFF};
    vecs[3]  = '{1'b1, 32'h8000_0088, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'd0};
    vecs[4]  = '{1'b1, 32'h8000_0008, 8'hF0, 64'hDEAD_BEEF_0000_0000, 64'd0};
    vecs[5]  = '{1'b0, 32'h8000_000D, 8'h00, 64'd0, 64'hDEAD_BEEF_89AB_CDEF};
    vecs[6]  = '{1'b1, 32'h8000_0080, 8'hFF, 64'h0000_0000_0000_A5A5, 64'd0};
    vecs[7]  = '{1'b0, 32'h8000_0000, 8'h00, 64'd0, 64'h0000_0000_0000_A5A5};
    vecs[8]  = '{1'b1, 32'h8000_0010, 8'hFF, 64'd0, 64'd0};
    vecs[9]  = '{1'b1, 32'h8000_0010, 8'h81, 64'hFF00_0000_0000_0011, 64'd0};
    vecs[10] = '{1'b0, 32'h8000_0010, 8'h00, 64'd0, 64'hFF00_0000_0000_0011};
    vecs[11] = '{1'b1, 32'h7FFF_FFF8, 8'hFF, 64'h0000_0000_0000_CAFE, 64'd0};
    vecs[12] = '{1'b0, 32'h8000_0078, 8'h00, 64'd0, 64'h0000_0000_0000_CAFE};
    vecs[13] = '{1'b0, 32'h8000_0100, 8'h00, 64'd0, 64'h0000_0000_0000_A5A5};

    rst = 1'b1;
    raddr_i = 32'h8000_0030; raddr_valid_i = 1'b1; rmask_i = 8'hFF; rsize_i = 4'b1000; rlen_i = 8'd0;
    waddr_i = 32'h8000_0030; waddr_valid_i = 1'b1; wmask_i = 8'hFF; wsize_i = 4'b1000;
    wlen_i = 8'd0; wdata_i = 64'h77;

    // Reset held with both valids high
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_rd_rdy", 64'(rdata_ready_o), 64'd0);
      check("rst_wr_rdy", 64'(wdata_ready_o), 64'd0);
      check("rst_rdata", rdata_o, 64'd0);
    end
    rst = 1'b0;
    raddr_valid_i = 1'b0;
    @(negedge clk);
    check("post_rst_accept", 64'(wdata_ready_o), 64'd1);
    waddr_valid_i = 1'b0;
    @(negedge clk);
    check("post_rst_turn", 64'(wdata_ready_o), 64'd0);

    // Table of single-beat writes and reads
    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].mask, vecs[i].data);
      end else begin
        exp_q[0] = vecs[i].exp;
        do_read(vecs[i].addr, 8'd0, -1);
      end
    end

    // Line refill of words 8..15
    for (int k = 0; k < 8; k++) begin
      do_write(32'h8000_0040 + 32'(8 * k), 8'hFF, 64'h1111_0000 + 64'(k));
      exp_q[k] = 64'h1111_0000 + 64'(k);
    end
    do_read(32'h8000_0040, 8'd7, -1);

    // Simultaneous write and read: write first, then one read beat
    @(negedge clk);
    waddr_i = 32'h8000_0200; wmask_i = 8'hFF; wdata_i = 64'h5; waddr_valid_i = 1'b1;
    raddr_i = 32'h8000_0200; rlen_i = 8'd0; raddr_valid_i = 1'b1;
    wr_at = -1; rd_at = -1; rbeats = 0; drop_r = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (drop_r) raddr_valid_i = 1'b0;
      if (wdata_ready_o) begin
        if (wr_at < 0) wr_at = i;
        waddr_valid_i = 1'b0;
      end
      if (rdata_ready_o) begin
        rbeats++;
        rd_at = i;
        drop_r = 1'b1;
        check("simul_rdata", rdata_o, 64'h5);
      end
    end
    raddr_valid_i = 1'b0;
    waddr_valid_i = 1'b0;
    check("simul_wr_at", 64'(wr_at), 64'd1);
    check("simul_rd_at", 64'(rd_at), 64'd5);
    check("simul_rbeats", 64'(rbeats), 64'd1);

    // Burst wraps from word 15 to word 0
    exp_q[0] = 64'h1111_0007;
    exp_q[1] = 64'h5;
    do_read(BASE + 32'h78, 8'd1, -1);

    // Reset after beat 3 of a refill, then a clean single read
    for (int k = 0; k < 8; k++) exp_q[k] = 64'h1111_0000 + 64'(k);
    do_read(32'h8000_0040, 8'd7, 3);
    exp_q[0] = 64'h1111_0001;
    do_read(32'h8000_0048, 8'd0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
